// File: rtl/timer_pkg.sv
// Shared constants and helpers for the game countdown timer.
// Count is held as binary total seconds and rendered to BCD on output.
package timer_pkg;

    localparam int COUNT_W     = 10;
    localparam int SEC_PER_MIN = 60;
    localparam int ADD_SEC     = 30;

    function automatic logic [COUNT_W-1:0] total_sec(
        input int min,
        input int sec
    );
        return COUNT_W'(min * SEC_PER_MIN + sec);
    endfunction

endpackage

// File: rtl/sec_to_bcd.sv
// Combinational split of a total-seconds value into M:SS BCD digits.
// Constant divisors only, so synthesis builds fixed logic, not a divider.
module sec_to_bcd
    import timer_pkg::*;
(
    input  logic [COUNT_W-1:0] secs,
    output logic [3:0]         min_ones,
    output logic [3:0]         sec_tens,
    output logic [3:0]         sec_ones
);

    logic [COUNT_W-1:0] rem;

    always_comb begin
        rem      = secs % COUNT_W'(SEC_PER_MIN);
        min_ones = 4'(secs / COUNT_W'(SEC_PER_MIN));
        sec_tens = 4'(rem / COUNT_W'(10));
        sec_ones = 4'(secs % COUNT_W'(10));
    end

endmodule

// File: rtl/countdown_bcd_timer.sv
// Game countdown: load, +30 s on request edge, 1 Hz decrement, saturating.
// Signals end-of-time to the game FSM and drives the time display digits.
module countdown_bcd_timer
    import timer_pkg::*;
#(
    parameter int START_MIN = 2,
    parameter int START_SEC = 0,
    parameter int MAX_MIN   = 9,
    parameter int WARN_SEC  = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       countLoadN,
    input  logic       countEnable,
    input  logic       add_thirtySecN,
    input  logic       OneSecPulse,
    output logic       timerEnd,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       lowTime
);

    localparam int SUM_W = COUNT_W + 1;

    localparam logic [SUM_W-1:0] CEIL =
        SUM_W'(MAX_MIN * SEC_PER_MIN + 59);
    localparam logic [COUNT_W-1:0] START_CNT =
        total_sec(START_MIN, START_SEC);
    localparam logic [COUNT_W-1:0] WARN_CNT = COUNT_W'(WARN_SEC);

    logic [COUNT_W-1:0] count_q, count_d;
    logic               add_n_dly_q, add_n_dly_d;
    logic               timer_end_q, timer_end_d;

    logic               add_edge;
    logic               dec;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   sat;
    logic [SUM_W-1:0]   nxt;

    always_comb begin
        count_d     = count_q;
        add_n_dly_d = add_thirtySecN;
        timer_end_d = 1'b0;

        add_edge = add_n_dly_q & ~add_thirtySecN;
        sum = {1'b0, count_q}
            + (add_edge ? SUM_W'(ADD_SEC) : SUM_W'(0));
        // Clamp before the tick so add+tick at the ceiling ends one below it.
        sat = (sum > CEIL) ? CEIL : sum;
        dec = OneSecPulse && (sat != '0);
        nxt = sat - SUM_W'(dec);

        if (!countLoadN) begin
            count_d = START_CNT;
        end else if (countEnable) begin
            count_d     = COUNT_W'(nxt);
            timer_end_d = dec && (nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q     <= '0;
            add_n_dly_q <= 1'b1;
            timer_end_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            add_n_dly_q <= add_n_dly_d;
            timer_end_q <= timer_end_d;
        end
    end

    sec_to_bcd u_bcd (
        .secs     (count_q),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones)
    );

    assign timerEnd = timer_end_q;
    assign lowTime  = (count_q != '0) && (count_q <= WARN_CNT);

endmodule

// File: tb/tb_countdown_bcd_timer.sv
// Bench for countdown_bcd_timer: seconds-level model checked every cycle,
// plus directed literal checkpoints on the displayed M:SS.
module tb_countdown_bcd_timer;

    localparam int START = 120;
    localparam int CEIL  = 599;
    localparam int WARN  = 10;

    logic       clk = 1'b0;
    logic       resetN;
    logic       countLoadN;
    logic       countEnable;
    logic       add_thirtySecN;
    logic       OneSecPulse;
    logic       timerEnd;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       lowTime;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    int m_count;
    bit m_addn;
    bit m_end;

    countdown_bcd_timer dut (
        .clk            (clk),
        .resetN         (resetN),
        .countLoadN     (countLoadN),
        .countEnable    (countEnable),
        .add_thirtySecN (add_thirtySecN),
        .OneSecPulse    (OneSecPulse),
        .timerEnd       (timerEnd),
        .min_ones       (min_ones),
        .sec_tens       (sec_tens),
        .sec_ones       (sec_ones),
        .lowTime        (lowTime)
    );

    always #5 clk = ~clk;

    // Behavioural model in whole seconds.
    always @(posedge clk or negedge resetN) begin
        int t;
        bit edge_seen;
        if (!resetN) begin
            m_count = 0;
            m_addn  = 1'b1;
            m_end   = 1'b0;
        end else begin
            edge_seen = m_addn && !add_thirtySecN;
            m_addn    = add_thirtySecN;
            m_end     = 1'b0;
            if (!countLoadN) begin
                m_count = START;
            end else if (countEnable) begin
                t = m_count + (edge_seen ? 30 : 0);
                if (t > CEIL) t = CEIL;
                if (OneSecPulse && t > 0) begin
                    t = t - 1;
                    if (t == 0) m_end = 1'b1;
                end
                m_count = t;
            end
        end
    end

    task automatic cmp(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("cyc_min_ones", int'(min_ones), m_count / 60);
            cmp("cyc_sec_tens", int'(sec_tens), (m_count % 60) / 10);
            cmp("cyc_sec_ones", int'(sec_ones), m_count % 10);
            cmp("cyc_lowTime", int'(lowTime),
                int'(m_count != 0 && m_count <= WARN));
            cmp("cyc_timerEnd", int'(timerEnd), int'(m_end));
        end
    end

    task automatic chk(input string nm, input int m, input int t,
                       input int o, input bit lt, input bit te);
        cmp({nm, "_min"}, int'(min_ones), m);
        cmp({nm, "_tens"}, int'(sec_tens), t);
        cmp({nm, "_ones"}, int'(sec_ones), o);
        cmp({nm, "_low"}, int'(lowTime), int'(lt));
        cmp({nm, "_end"}, int'(timerEnd), int'(te));
        cmp({nm, "_model"}, m_count, m * 60 + t * 10 + o);
    endtask

    task automatic cyc(input logic l, input logic e,
                       input logic a, input logic t);
        countLoadN     = l;
        countEnable    = e;
        add_thirtySecN = a;
        OneSecPulse    = t;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN         = 1'b0;
        countLoadN     = 1'b1;
        countEnable    = 1'b0;
        add_thirtySecN = 1'b1;
        OneSecPulse    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        chk("reset", 0, 0, 0, 1'b0, 1'b0);
        resetN = 1'b1;

        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("load", 2, 0, 0, 1'b0, 1'b0);

        for (int i = 1; i <= 120; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b1);
            if (i == 109) chk("t0_11", 0, 1, 1, 1'b0, 1'b0);
            if (i == 110) chk("t0_10", 0, 1, 0, 1'b1, 1'b0);
            if (i == 119) chk("t0_01", 0, 0, 1, 1'b1, 1'b0);
            if (i == 120) chk("t0_00", 0, 0, 0, 1'b0, 1'b1);
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("after_end", 0, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("no_repeat", 0, 0, 0, 1'b0, 1'b0);

        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 75; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("at0_45", 0, 4, 5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("held_add", 1, 1, 5, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("second_add", 1, 4, 5, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("at9_40", 9, 4, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat", 9, 5, 9, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("at9_50", 9, 5, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("sat_tick", 9, 5, 8, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);

        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("at1_00", 1, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("add_tick", 1, 2, 9, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 88; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("at0_01", 0, 0, 1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("rescue", 0, 3, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rescue_noend", 0, 3, 0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("frozen", 0, 3, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("reenable", 0, 3, 0, 1'b0, 1'b0);

        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("load_tick", 2, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("post_load", 2, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 37; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("at1_23", 1, 2, 3, 1'b0, 1'b0);
        #2 resetN = 1'b0;
        #1 chk("async_rst", 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_hold", 0, 0, 0, 1'b0, 1'b0);
        resetN = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("post_rst", 0, 0, 0, 1'b0, 1'b0);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
